// File: rtl/display_shift_out_pkg.sv
// Shared register map, status bit positions and FSM state encoding for the
// front-panel display shift-out peripheral.
package display_shift_out_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic overrun);
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY]    = busy;
        w[STAT_DONE]    = done;
        w[STAT_OVERRUN] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/shift_out_core.sv
// Serializer engine: shifts one word MSB-first on ser_clk/ser_data, then pulses
// ser_latch. Serial pins are registered from the next-state decode so they never glitch.
module shift_out_core
    import display_shift_out_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_busy,
    output logic              o_done_pulse,
    output logic              o_ser_clk,
    output logic              o_ser_data,
    output logic              o_ser_latch
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_bit;
    logic [CNT_W-1:0]    w_bit_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_div_done;
    logic                w_done_pulse;
    logic                r_ser_clk;
    logic                r_ser_data;
    logic                r_ser_latch;

    assign w_div_done = (r_div == '0);

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_done_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = SHIFT_LO;
                    w_shift_next = i_word;
                    w_bit_next   = CNT_W'(DATA_W - 1);
                end
            end
            SHIFT_LO: begin
                if (w_div_done) begin
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_div_done) begin
                    if (r_bit == '0) begin
                        w_state_next = LATCH;
                    end else begin
                        // Next bit goes out on the same edge ser_clk falls.
                        w_state_next = SHIFT_LO;
                        w_bit_next   = r_bit - CNT_W'(1);
                        w_shift_next = r_shift << 1;
                    end
                end
            end
            LATCH: begin
                if (w_div_done) begin
                    w_state_next = IDLE;
                    w_done_pulse = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_ser_clk   <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_latch <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            if (w_state_next != r_state) begin
                r_div <= DIV_W'(CLK_DIV - 1);
            end else if (!w_div_done) begin
                r_div <= r_div - DIV_W'(1);
            end
            r_ser_clk   <= (w_state_next == SHIFT_HI);
            r_ser_data  <= ((w_state_next == SHIFT_LO) || (w_state_next == SHIFT_HI))
                           && w_shift_next[DATA_W-1];
            r_ser_latch <= (w_state_next == LATCH);
        end
    end

    assign o_busy       = (r_state != IDLE);
    assign o_done_pulse = w_done_pulse;
    assign o_ser_clk    = r_ser_clk;
    assign o_ser_data   = r_ser_data;
    assign o_ser_latch  = r_ser_latch;

endmodule

// File: rtl/display_shift_out.sv
// Avalon-MM front end for the display shift-out chain: register file, sticky
// done/overrun flags, interrupt and registered read mux around shift_out_core.
module display_shift_out
    import display_shift_out_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        ser_clk,
    output logic        ser_data,
    output logic        ser_latch
);

    logic              w_write;
    logic              w_wr_data;
    logic              w_wr_mask;
    logic              w_wr_clear;
    logic              w_start;
    logic              w_overrun_set;
    logic              w_busy;
    logic              w_done_pulse;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wdata;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              r_overrun;
    logic              r_irq_mask;
    logic [31:0]       r_readdata;

    assign w_write       = chipselect & ~write_n;
    assign w_wr_data     = w_write && (address == ADDR_DATA);
    assign w_wr_mask     = w_write && (address == ADDR_MASK);
    assign w_wr_clear    = w_write && (address == ADDR_CLEAR);
    assign w_start       = w_wr_data & ~w_busy;
    assign w_overrun_set = w_wr_data & w_busy;
    assign w_unused_wdata = &{1'b0, writedata};

    shift_out_core #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (w_start),
        .i_word       (writedata[DATA_W-1:0]),
        .o_busy       (w_busy),
        .o_done_pulse (w_done_pulse),
        .o_ser_clk    (ser_clk),
        .o_ser_data   (ser_data),
        .o_ser_latch  (ser_latch)
    );

    // A completing transfer wins over a simultaneous CLEAR so done is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_irq_mask <= 1'b0;
        end else begin
            if (w_start) begin
                r_data <= writedata[DATA_W-1:0];
            end
            if (w_done_pulse) begin
                r_done <= 1'b1;
            end else if (w_wr_clear) begin
                r_done <= 1'b0;
            end
            if (w_wr_clear) begin
                r_overrun <= 1'b0;
            end else if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
            if (w_wr_mask) begin
                r_irq_mask <= writedata[0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux = 32'(r_data);
            ADDR_STATUS: w_rd_mux = status_word(w_busy, r_done, r_overrun);
            ADDR_MASK:   w_rd_mux = {31'd0, r_irq_mask};
            ADDR_CLEAR:  w_rd_mux = '0;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_done & r_irq_mask;

endmodule

// File: tb/tb_display_shift_out.sv
// Self-checking bench for display_shift_out: directed and randomized transfers
// compared cycle by cycle against a timeline model of the serial protocol.
module tb_display_shift_out;

    localparam int DW    = 16;
    localparam int CD    = 4;
    localparam int END_T = (2 * DW + 1) * CD;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_MASK   = 2'd2;
    localparam logic [1:0] A_CLEAR  = 2'd3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;
    logic          ser_clk;
    logic          ser_data;
    logic          ser_latch;

    int            cmpCount = 0;
    int            errCount = 0;
    logic          mdlMask = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic [31:0]   rd;

    display_shift_out #(
        .DATA_W  (DW),
        .CLK_DIV (CD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation time limit expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {ser_clk, ser_data, ser_latch} t cycles after the accepting edge.
    function automatic logic [2:0] mdlPins(input int t, input logic [DW-1:0] w);
        int   ph;
        logic b;
        ph = t / CD;
        if (ph < 2 * DW) begin
            b = w[DW - 1 - ph / 2];
            return {1'(ph % 2), b, 1'b0};
        end else if (ph == 2 * DW) begin
            return 3'b001;
        end
        return 3'b000;
    endfunction

    // Expected STATUS after edge E0+s, given optional DATA write / CLEAR write cycles.
    function automatic logic [31:0] mdlStatus(input int s, input int injAt, input int clrAt);
        logic busy, done, ovr;
        int   si, sc;
        si   = injAt + 1;
        sc   = clrAt + 1;
        busy = (s < END_T);
        done = (s >= END_T);
        ovr  = (injAt >= 0) && (s >= si) && !((clrAt >= 0) && (s >= sc) && (sc > si));
        return {29'd0, ovr, done, busy};
    endfunction

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        if (a == A_MASK) mdlMask = d[0];
    endtask

    task automatic readRegister(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic runTransfer(input logic [DW-1:0] word, input int injAt, input int clrAt,
                               input string tag);
        logic [31:0]   rnd;
        logic [31:0]   expRd;
        logic [31:0]   back;
        logic [DW-1:0] sampled;
        int            rises;
        int            latchCycles;
        logic          prevClk;
        applyStimulus(A_CLEAR, 32'd0);
        rnd        = $urandom;
        address    = A_DATA;
        writedata  = {rnd[31:16], word};
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        sampled     = '0;
        rises       = 0;
        latchCycles = 0;
        prevClk     = 1'b0;
        for (int t = 0; t <= END_T + 2; t++) begin
            checkOutput({tag, " pins"}, 32'({ser_clk, ser_data, ser_latch}), 32'(mdlPins(t, word)));
            checkOutput({tag, " irq"}, 32'(irq), 32'(mdlMask && (t >= END_T)));
            if (t == 0)                          expRd = 32'(prevData);
            else if (injAt >= 0 && t == injAt + 1) expRd = 32'(word);
            else if (clrAt >= 0 && t == clrAt + 1) expRd = 32'd0;
            else                                 expRd = mdlStatus(t - 1, injAt, clrAt);
            checkOutput({tag, " readdata"}, readdata, expRd);
            if (ser_clk && !prevClk) begin
                sampled = {sampled[DW-2:0], ser_data};
                rises++;
            end
            prevClk = ser_clk;
            if (ser_latch) latchCycles++;
            chipselect = 1'b1;
            if (t == injAt) begin
                address   = A_DATA;
                writedata = 32'h0000_FFFF;
                write_n   = 1'b0;
            end else if (t == clrAt) begin
                address   = A_CLEAR;
                writedata = 32'd0;
                write_n   = 1'b0;
            end else begin
                address = A_STATUS;
                write_n = 1'b1;
            end
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        checkOutput({tag, " rising edges"}, 32'(rises), 32'(DW));
        checkOutput({tag, " shifted word"}, 32'(sampled), 32'(word));
        checkOutput({tag, " latch cycles"}, 32'(latchCycles), 32'(CD));
        readRegister(A_DATA, back);
        checkOutput({tag, " data readback"}, back, 32'(word));
        prevData = word;
    endtask

    task automatic resetMidTransfer(input logic [DW-1:0] word);
        int latchSeen;
        int activeSeen;
        applyStimulus(A_CLEAR, 32'd0);
        address    = A_DATA;
        writedata  = 32'(word);
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int t = 0; t < 50; t++) begin
            checkOutput("pre-reset pins", 32'({ser_clk, ser_data, ser_latch}), 32'(mdlPins(t, word)));
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        mdlMask  = 1'b0;
        prevData = '0;
        checkOutput("reset pins", 32'({ser_clk, ser_data, ser_latch, irq}), 32'd0);
        checkOutput("reset readdata", readdata, 32'd0);
        latchSeen  = 0;
        activeSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ser_latch) latchSeen++;
            if (ser_clk || ser_data) activeSeen++;
        end
        reset_n = 1'b1;
        repeat (END_T) begin
            @(negedge clk);
            if (ser_latch) latchSeen++;
            if (ser_clk || ser_data) activeSeen++;
        end
        checkOutput("post-reset latch pulses", 32'(latchSeen), 32'd0);
        checkOutput("post-reset serial activity", 32'(activeSeen), 32'd0);
        readRegister(A_STATUS, rd);
        checkOutput("post-reset status", rd, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        int            inj;
        int            clr;
        $display("[TB] starting display_shift_out bench");
        repeat (3) @(negedge clk);
        checkOutput("in-reset pins", 32'({ser_clk, ser_data, ser_latch, irq}), 32'd0);
        checkOutput("in-reset readdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            readRegister(2'(a), rd);
            checkOutput($sformatf("reset read addr%0d", a), rd, 32'd0);
        end
        checkOutput("idle pins", 32'({ser_clk, ser_data, ser_latch, irq}), 32'd0);

        runTransfer(16'hA5C3, -1, -1, "A5C3");
        readRegister(A_STATUS, rd);
        checkOutput("A5C3 status", rd, 32'h2);

        applyStimulus(A_MASK, 32'hFFFF_FFFF);
        readRegister(A_MASK, rd);
        checkOutput("mask readback", rd, 32'h1);
        w = 16'($urandom);
        runTransfer(w, -1, -1, "irq");
        applyStimulus(A_CLEAR, 32'd0);
        checkOutput("irq after clear", 32'(irq), 32'd0);
        readRegister(A_STATUS, rd);
        checkOutput("status after clear", rd, 32'd0);

        runTransfer(16'h1234, 9, -1, "overrun");
        w = 16'($urandom);
        runTransfer(w, END_T - 1, -1, "write on latch exit");
        w = 16'($urandom);
        runTransfer(w, 20, END_T - 1, "clear on done");

        w = 16'($urandom);
        resetMidTransfer(w);
        w = 16'($urandom);
        runTransfer(w, -1, -1, "after reset");

        for (int n = 0; n < 4; n++) begin
            applyStimulus(A_MASK, 32'($urandom_range(0, 1)));
            w   = 16'($urandom);
            inj = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, END_T - 1));
            clr = -1;
            if (inj >= 0 && inj < END_T - 1 && $urandom_range(0, 1) == 1)
                clr = int'($urandom_range(inj + 1, END_T - 1));
            runTransfer(w, inj, clr, $sformatf("random%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
